// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_pkg
// Purpose  : Constants shared by the RV32I front-end blocks: data width,
//            canonical NOP encoding, default reset PC and default
//            instruction-memory word-address width.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int          C_XLEN     = 32;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam int          C_IM_AW    = 6;              // 64-word IM

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register. One entry: PC, PC+4, instruction,
//            valid bit and the two fetch-fault flags.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            load              - capture d_* as a valid entry
//            clear             - replace the entry with an invalid NOP
//            d_*               - entry to capture
//            q_*               - registered entry
//            Neither load nor clear: the entry holds.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc_plus4,
    input  logic [31:0] d_instr,
    input  logic        d_misaligned,
    input  logic        d_oob,
    output logic [31:0] q_pc,
    output logic [31:0] q_pc_plus4,
    output logic [31:0] q_instr,
    output logic        q_valid,
    output logic        q_misaligned,
    output logic        q_oob
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_pc         <= '0;
            q_pc_plus4   <= '0;
            q_instr      <= C_NOP;
            q_valid      <= 1'b0;
            q_misaligned <= 1'b0;
            q_oob        <= 1'b0;
        end else if (clear) begin
            // PC fields are left as they were; only the payload is killed.
            q_instr      <= C_NOP;
            q_valid      <= 1'b0;
            q_misaligned <= 1'b0;
            q_oob        <= 1'b0;
        end else if (load) begin
            q_pc         <= d_pc;
            q_pc_plus4   <= d_pc_plus4;
            q_instr      <= d_instr;
            q_valid      <= 1'b1;
            q_misaligned <= d_misaligned;
            q_oob        <= d_oob;
        end
    end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch. Holds the PC, drives the IM word address,
//            captures the same-cycle IM read into the IF/ID register and
//            counts valid captures.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            stall                     - hold PC and IF/ID
//            flush                     - invalidate IF/ID
//            redirect, redirect_pc     - taken branch/jump target
//            addres, rd                - IM word address / read data
//            if_pc, if_pc_plus4, if_instr, if_valid,
//            if_misaligned, if_oob     - IF/ID entry
//            if_count                  - valid captures since reset
//            Edge priority: rst > redirect > stall > advance.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter int          IM_AW    = C_IM_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] addres,
    input  logic [31:0]      rd,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    output logic [31:0]      if_instr,
    output logic             if_valid,
    output logic             if_misaligned,
    output logic             if_oob,
    output logic [31:0]      if_count
);

    logic [31:0] r_pc;
    logic [31:0] r_count;
    logic [31:0] w_pc_plus4;
    logic        w_misaligned;
    logic        w_oob;
    logic [31:0] w_instr;
    logic        w_load;
    logic        w_clear;

    assign w_pc_plus4   = r_pc + 32'd4;   // wraps modulo 2^32
    assign w_misaligned = |r_pc[1:0];
    assign w_oob        = |r_pc[C_XLEN-1:IM_AW+2];
    // A faulting fetch still makes a valid entry, but never forwards rd.
    assign w_instr      = (w_misaligned || w_oob) ? C_NOP : rd;

    // Redirect overrides stall and always kills the entry being fetched.
    assign w_load  = !redirect && !stall && !flush;
    assign w_clear = redirect || flush;

    assign addres   = r_pc[IM_AW+1:2];
    assign if_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc <= redirect_pc;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= r_count + 32'd1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (w_load),
        .clear        (w_clear),
        .d_pc         (r_pc),
        .d_pc_plus4   (w_pc_plus4),
        .d_instr      (w_instr),
        .d_misaligned (w_misaligned),
        .d_oob        (w_oob),
        .q_pc         (if_pc),
        .q_pc_plus4   (if_pc_plus4),
        .q_instr      (if_instr),
        .q_valid      (if_valid),
        .q_misaligned (if_misaligned),
        .q_oob        (if_oob)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. Each step drives one
//            cycle of controls, pushes the expected post-edge state into a
//            scoreboard queue and pops/compares it #1 after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          flush;
        bit          redirect;
        logic [31:0] rpc;
        logic [5:0]  e_addres;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [31:0] e_instr;
        bit          e_valid;
        bit          e_mis;
        bit          e_oob;
        logic [31:0] e_count;
        bit          pc_dc;     // if_pc/if_pc_plus4 not checked
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [5:0]  addres;
    logic [31:0] rd;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        if_misaligned;
    logic        if_oob;
    logic [31:0] if_count;

    logic [31:0] mem [64];
    vec_t        sb_q[$];
    vec_t        tbl[19];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    assign rd = mem[addres];

    fetch_stage #(.RESET_PC(32'h0000_0000), .IM_AW(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .addres        (addres),
        .rd            (rd),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_instr      (if_instr),
        .if_valid      (if_valid),
        .if_misaligned (if_misaligned),
        .if_oob        (if_oob),
        .if_count      (if_count)
    );

    function automatic vec_t mk(bit r, bit s, bit f, bit rdr, logic [31:0] rpc,
                                logic [5:0] a, logic [31:0] pc, logic [31:0] p4,
                                logic [31:0] ins, bit val, bit mis, bit oob,
                                logic [31:0] cnt, bit dc);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.redirect = rdr; v.rpc = rpc;
        v.e_addres = a; v.e_pc = pc; v.e_p4 = p4; v.e_instr = ins;
        v.e_valid = val; v.e_mis = mis; v.e_oob = oob; v.e_count = cnt;
        v.pc_dc = dc;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        sb_q.push_back(v);
        rst         = v.rst;
        stall       = v.stall;
        flush       = v.flush;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("addres",   idx, {26'd0, addres}, {26'd0, e.e_addres});
        if (!e.pc_dc) begin
            chk("if_pc",       idx, if_pc,       e.e_pc);
            chk("if_pc_plus4", idx, if_pc_plus4, e.e_p4);
        end
        chk("if_instr",      idx, if_instr,             e.e_instr);
        chk("if_valid",      idx, {31'd0, if_valid},      {31'd0, e.e_valid});
        chk("if_misaligned", idx, {31'd0, if_misaligned}, {31'd0, e.e_mis});
        chk("if_oob",        idx, {31'd0, if_oob},        {31'd0, e.e_oob});
        chk("if_count",      idx, if_count,             e.e_count);
    endtask

    initial begin
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0000_0013;
        for (int i = 4; i < 64; i++) mem[i] = 32'hA000_0000 | i;

        //            r s f rd rpc            addr pc            p4            instr          v m o cnt dc
        tbl[0]  = mk(0,0,0,0, 32'h0,        6'd1,  32'h0,        32'h4,        32'h0050_0093, 1,0,0, 1, 0);
        tbl[1]  = mk(0,0,0,0, 32'h0,        6'd2,  32'h4,        32'h8,        32'h00A0_0113, 1,0,0, 2, 0);
        tbl[2]  = mk(0,0,0,0, 32'h0,        6'd3,  32'h8,        32'hC,        32'h0020_81B3, 1,0,0, 3, 0);
        tbl[3]  = mk(0,0,0,0, 32'h0,        6'd4,  32'hC,        32'h10,       32'h0000_0013, 1,0,0, 4, 0);
        tbl[4]  = mk(0,1,0,1, 32'h20,       6'd8,  32'h0,        32'h0,        NOP,           0,0,0, 4, 1);
        tbl[5]  = mk(0,0,0,0, 32'h0,        6'd9,  32'h20,       32'h24,       32'hA000_0008, 1,0,0, 5, 0);
        tbl[6]  = mk(0,0,0,1, 32'h22,       6'd8,  32'h0,        32'h0,        NOP,           0,0,0, 5, 1);
        tbl[7]  = mk(0,0,0,0, 32'h0,        6'd9,  32'h22,       32'h26,       NOP,           1,1,0, 6, 0);
        tbl[8]  = mk(0,0,0,1, 32'h100,      6'd0,  32'h0,        32'h0,        NOP,           0,0,0, 6, 1);
        tbl[9]  = mk(0,0,0,0, 32'h0,        6'd1,  32'h100,      32'h104,      NOP,           1,0,1, 7, 0);
        tbl[10] = mk(0,0,0,1, 32'h102,      6'd0,  32'h0,        32'h0,        NOP,           0,0,0, 7, 1);
        tbl[11] = mk(0,0,0,0, 32'h0,        6'd1,  32'h102,      32'h106,      NOP,           1,1,1, 8, 0);
        tbl[12] = mk(0,0,0,1, 32'hFFFF_FFFC,6'd63, 32'h0,        32'h0,        NOP,           0,0,0, 8, 1);
        tbl[13] = mk(0,0,0,0, 32'h0,        6'd0,  32'hFFFF_FFFC,32'h0,        NOP,           1,0,1, 9, 0);
        tbl[14] = mk(0,0,0,0, 32'h0,        6'd1,  32'h0,        32'h4,        32'h0050_0093, 1,0,0, 10, 0);
        tbl[15] = mk(0,0,1,0, 32'h0,        6'd2,  32'h0,        32'h0,        NOP,           0,0,0, 10, 1);
        tbl[16] = mk(0,0,0,0, 32'h0,        6'd3,  32'h8,        32'hC,        32'h0020_81B3, 1,0,0, 11, 0);
        tbl[17] = mk(0,1,0,0, 32'h0,        6'd3,  32'h8,        32'hC,        32'h0020_81B3, 1,0,0, 11, 0);
        tbl[18] = mk(0,0,0,0, 32'h0,        6'd4,  32'hC,        32'h10,       32'h0000_0013, 1,0,0, 12, 0);

        // Reset: all outputs at reset values, addres = RESET_PC word.
        step(mk(1,0,0,0, 32'h0, 6'd0, 32'h0, 32'h0, NOP, 0,0,0, 0, 0), 100);
        step(mk(1,0,0,0, 32'h0, 6'd0, 32'h0, 32'h0, NOP, 0,0,0, 0, 0), 101);

        for (int i = 0; i < 19; i++) step(tbl[i], i);

        // Stall held three cycles with pc=8 and if_pc=4, then release.
        step(mk(1,0,0,0, 32'h0, 6'd0, 32'h0, 32'h0, NOP, 0,0,0, 0, 0), 200);
        step(mk(0,0,0,0, 32'h0, 6'd1, 32'h0, 32'h4, 32'h0050_0093, 1,0,0, 1, 0), 201);
        step(mk(0,0,0,0, 32'h0, 6'd2, 32'h4, 32'h8, 32'h00A0_0113, 1,0,0, 2, 0), 202);
        for (int i = 0; i < 3; i++)
            step(mk(0,1,0,0, 32'h0, 6'd2, 32'h4, 32'h8, 32'h00A0_0113, 1,0,0, 2, 0), 203 + i);
        step(mk(0,0,0,0, 32'h0, 6'd3, 32'h8, 32'hC, 32'h0020_81B3, 1,0,0, 3, 0), 206);

        // Stall+flush: pc held at C, entry cleared; then reset mid-sequence,
        // including a reset that arrives together with a redirect.
        step(mk(0,1,1,0, 32'h0,  6'd3, 32'h0, 32'h0, NOP, 0,0,0, 3, 1), 300);
        step(mk(0,1,1,0, 32'h0,  6'd3, 32'h0, 32'h0, NOP, 0,0,0, 3, 1), 301);
        step(mk(1,1,1,0, 32'h0,  6'd0, 32'h0, 32'h0, NOP, 0,0,0, 0, 0), 302);
        step(mk(1,0,0,1, 32'h40, 6'd0, 32'h0, 32'h0, NOP, 0,0,0, 0, 0), 303);
        step(mk(0,0,0,0, 32'h0,  6'd1, 32'h0, 32'h4, 32'h0050_0093, 1,0,0, 1, 0), 304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
